// File: rtl/fft_pkg.sv
// Shared definitions for the FFT front-end: loader FSM encoding, bank count
// and frame-length helper.
package fft_pkg;

  localparam int NUM_BANKS = 4;
  localparam int BANK_W    = $clog2(NUM_BANKS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FIRE,
    ST_WAIT_LO,
    ST_WAIT_HI
  } state_t;

  function automatic int frame_len(input int a_bit);
    return NUM_BANKS << a_bit;
  endfunction

endpackage

// File: rtl/fft_input_loader_if.sv
// Sample stream, RAM write port and sequencer handshake of the FFT input loader.
// Signal names carry their direction as seen from the loader.
interface fft_input_loader_if #(
  parameter int A_BIT = 10,
  parameter int D_BIT = 16
);
  import fft_pkg::*;

  logic [D_BIT-1:0]  iDATA_RE;
  logic [D_BIT-1:0]  iDATA_IM;
  logic              iVALID;
  logic              iSOP;
  logic              oREADY;
  logic              oWE;
  logic [BANK_W-1:0] oWR_BANK;
  logic [A_BIT-1:0]  oWR_ADDR;
  logic [D_BIT-1:0]  oWR_DATA_RE;
  logic [D_BIT-1:0]  oWR_DATA_IM;
  logic              oSTART;
  logic              iFFT_RDY;
  logic              oBUSY;
  logic              oERR;
  logic              iCLR_ERR;

  modport slave (
    input  iDATA_RE, iDATA_IM, iVALID, iSOP, iFFT_RDY, iCLR_ERR,
    output oREADY, oWE, oWR_BANK, oWR_ADDR, oWR_DATA_RE, oWR_DATA_IM,
           oSTART, oBUSY, oERR
  );

  modport master (
    output iDATA_RE, iDATA_IM, iVALID, iSOP, iFFT_RDY, iCLR_ERR,
    input  oREADY, oWE, oWR_BANK, oWR_ADDR, oWR_DATA_RE, oWR_DATA_IM,
           oSTART, oBUSY, oERR
  );

endinterface

// File: rtl/fft_input_wr_reg.sv
// One-cycle registered write port into the four FFT data RAM banks.
// The top bits of the sample index select the bank, the rest address it.
module fft_input_wr_reg
  import fft_pkg::*;
#(
  parameter int A_BIT = 10,
  parameter int D_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [A_BIT+1:0]  idx_i,
  input  logic [D_BIT-1:0]  re_i,
  input  logic [D_BIT-1:0]  im_i,
  output logic              we_o,
  output logic [BANK_W-1:0] bank_o,
  output logic [A_BIT-1:0]  addr_o,
  output logic [D_BIT-1:0]  re_o,
  output logic [D_BIT-1:0]  im_o
);

  logic              we_q;
  logic [BANK_W-1:0] bank_q;
  logic [A_BIT-1:0]  addr_q;
  logic [D_BIT-1:0]  re_q;
  logic [D_BIT-1:0]  im_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q   <= 1'b0;
      bank_q <= '0;
      addr_q <= '0;
      re_q   <= '0;
      im_q   <= '0;
    end else begin
      we_q <= we_i;
      if (we_i) begin
        bank_q <= idx_i[A_BIT+1:A_BIT];
        addr_q <= idx_i[A_BIT-1:0];
        re_q   <= re_i;
        im_q   <= im_i;
      end
    end
  end

  assign we_o   = we_q;
  assign bank_o = bank_q;
  assign addr_o = addr_q;
  assign re_o   = re_q;
  assign im_o   = im_q;

endmodule

// File: rtl/fft_input_loader.sv
// Loads one complex frame in natural order into the FFT RAM banks, then
// starts the sequencer and holds off input until it has finished.
module fft_input_loader
  import fft_pkg::*;
#(
  parameter int A_BIT = 10,
  parameter int D_BIT = 16
) (
  input  logic               iCLK,
  input  logic               iRESET,
  fft_input_loader_if.slave  bus
);

  localparam int              CNT_W    = A_BIT + 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(frame_len(A_BIT) - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wr_idx;
  logic             accept;
  logic             wr_en;
  logic             err_set;
  logic             err_q, err_d;
  logic             start_q;

  assign bus.oREADY = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign accept     = bus.iVALID & bus.oREADY;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = '0;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.iSOP) begin
            wr_en   = 1'b1;
            cnt_d   = CNT_W'(1);
            state_d = ST_LOAD;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          // A stray SOP restarts the frame with this sample as index 0
          if (bus.iSOP) begin
            err_set = 1'b1;
            cnt_d   = CNT_W'(1);
          end else begin
            wr_idx = cnt_q;
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              state_d = ST_FIRE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      ST_FIRE:    state_d = ST_WAIT_LO;
      ST_WAIT_LO: if (!bus.iFFT_RDY) state_d = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (bus.iFFT_RDY) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  assign err_d = err_set | (err_q & ~bus.iCLR_ERR);

  // Start is registered out of FIRE so it trails the final RAM write by a cycle
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      start_q <= (state_q == ST_FIRE);
    end
  end

  assign bus.oSTART = start_q;
  assign bus.oBUSY  = (state_q != ST_IDLE);
  assign bus.oERR   = err_q;

  fft_input_wr_reg #(
    .A_BIT(A_BIT),
    .D_BIT(D_BIT)
  ) u_wr_reg (
    .clk    (iCLK),
    .rst    (iRESET),
    .we_i   (wr_en),
    .idx_i  (wr_idx),
    .re_i   (bus.iDATA_RE),
    .im_i   (bus.iDATA_IM),
    .we_o   (bus.oWE),
    .bank_o (bus.oWR_BANK),
    .addr_o (bus.oWR_ADDR),
    .re_o   (bus.oWR_DATA_RE),
    .im_o   (bus.oWR_DATA_IM)
  );

endmodule
